// File: rtl/gf16_inverse_seq_pkg.sv
// Shared definitions for the GF(2^4) inverse unit (polynomial x^4+x+1).
// Holds the reduction constant, the serial multiply length, the FSM state
// encoding, the multiplier operand-select encoding and the xtime helper.
package gf16_inverse_seq_pkg;

   // Low terms of the reduction polynomial: x^4 = x + 1.
   localparam logic [3:0] POLY_LOW = 4'b0011;
   // Cycles per serial multiply: 1 load + 4 bit iterations. Tied to the 4-bit width.
   localparam int MUL_CYC = 5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_M1   = 3'd1,
      S_M2   = 3'd2,
      S_M3   = 3'd3,
      S_M4   = 3'd4,
      S_M5   = 3'd5,
      S_FIN  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      SRC_A = 2'd0,
      SRC_R = 2'd1,
      SRC_S = 2'd2
   } src_t;

   // Multiply by x, reducing the overflow bit back into the low terms.
   function automatic logic [3:0] xtime(input logic [3:0] v);
      return {v[2:0], 1'b0} ^ (v[3] ? POLY_LOW : 4'h0);
   endfunction

endpackage

// File: rtl/gf16_inverse_seq_if.sv
// Handshake bundle for gf16_inverse_seq.
//   start    : request pulse (master -> slave), sampled only when busy=0
//   operand  : element a, captured with an accepted start
//   busy     : operation in progress, including the done cycle
//   done     : one-cycle completion pulse
//   result   : a^-1, held until the next done
//   zero_err : set with done when a==0, held until the next done
interface gf16_inverse_seq_if;
   logic       start;
   logic [3:0] operand;
   logic       busy;
   logic       done;
   logic [3:0] result;
   logic       zero_err;

   modport master (output start, operand, input busy, done, result, zero_err);
   modport slave  (input start, operand, output busy, done, result, zero_err);
endinterface

// File: rtl/gf16_inverse_seq_mul_serial.sv
// Serial MSB-first shift-XOR multiplier over GF(2^4).
//   clk, rst : clock, asynchronous active-high reset (aborts a multiply)
//   ld       : load x/y and clear the accumulator
//   x, y     : operands, sampled on the ld edge
//   p        : product; valid while p_vld is high
//   p_vld    : high in the last iteration cycle, the fifth cycle counting
//              the load cycle as the first
// The final iteration is presented combinationally on p so the caller can
// write the product back on the same edge that would otherwise only update
// the accumulator; this keeps each multiply at exactly five cycles.
module gf16_mul_serial
   import gf16_inverse_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ld,
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [3:0] p,
   output logic       p_vld
);

   logic [3:0] xr, yr, acc, acc_nxt;
   logic [1:0] idx;
   logic       run;

   // acc' = xtime(acc) ^ (y[i] ? x : 0), walking y from bit 3 down to bit 0.
   assign acc_nxt = xtime(acc) ^ (yr[idx] ? xr : 4'h0);
   assign p       = acc_nxt;
   assign p_vld   = run && (idx == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xr  <= 4'h0;
         yr  <= 4'h0;
         acc <= 4'h0;
         idx <= 2'd0;
         run <= 1'b0;
      end else if (ld) begin
         xr  <= x;
         yr  <= y;
         acc <= 4'h0;
         idx <= 2'd3;
         run <= 1'b1;
      end else if (run) begin
         acc <= acc_nxt;
         idx <= idx - 2'd1;
         run <= (idx != 2'd0);
      end
   end

endmodule

// File: rtl/gf16_inverse_seq.sv
// Sequential multiplicative inverse over GF(2^4): a^-1 = a^14, built from
// a^2, a^4, a^6, a^8, a^14 with one shared serial multiplier.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; an interrupted operation yields no done
//   bus  : start/operand in, busy/done/result/zero_err out
// Latency is fixed: done is in the 26th cycle after the start-sampling edge
// (five 5-cycle multiplies plus the done cycle), independent of the data.
module gf16_inverse_seq
   import gf16_inverse_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   gf16_inverse_seq_if.slave  bus
);

   localparam logic [2:0] CNT_LAST = 3'(MUL_CYC - 1);

   state_t     state, state_nxt, step_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [3:0] a, r, s, x, y, p, result_q;
   logic       zero_q, p_vld, ld, in_mul;
   logic       cap_a, wr_r, wr_s, wr_res;
   src_t       src_x, src_y;

   function automatic logic [3:0] pick(input src_t sel, input logic [3:0] va,
                                       input logic [3:0] vr, input logic [3:0] vs);
      case (sel)
         SRC_A:   return va;
         SRC_R:   return vr;
         SRC_S:   return vs;
         default: return 4'h0;
      endcase
   endfunction

   assign x = pick(src_x, a, r, s);
   assign y = pick(src_y, a, r, s);

   gf16_mul_serial u_mul (
      .clk   (clk),
      .rst   (rst),
      .ld    (ld),
      .x     (x),
      .y     (y),
      .p     (p),
      .p_vld (p_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      step_nxt  = S_IDLE;
      cnt_nxt   = 3'd0;
      in_mul    = 1'b0;
      ld        = 1'b0;
      cap_a     = 1'b0;
      wr_r      = 1'b0;
      wr_s      = 1'b0;
      wr_res    = 1'b0;
      src_x     = SRC_A;
      src_y     = SRC_A;
      case (state)
         S_IDLE: if (bus.start) begin
            cap_a     = 1'b1;
            state_nxt = S_M1;
         end
         S_M1: begin in_mul = 1'b1; step_nxt = S_M2;                 wr_r = p_vld; end
         S_M2: begin in_mul = 1'b1; step_nxt = S_M3; src_x = SRC_R; src_y = SRC_R; wr_s = p_vld; end
         S_M3: begin in_mul = 1'b1; step_nxt = S_M4; src_x = SRC_R; src_y = SRC_S; wr_r = p_vld; end
         S_M4: begin in_mul = 1'b1; step_nxt = S_M5; src_x = SRC_S; src_y = SRC_S; wr_s = p_vld; end
         S_M5: begin
            in_mul = 1'b1; step_nxt = S_FIN; src_x = SRC_R; src_y = SRC_S;
            wr_r   = p_vld;
            wr_res = p_vld;
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Common step sequencing: load on count 0, advance after the last iteration.
      if (in_mul) begin
         ld = (cnt == 3'd0);
         if (cnt == CNT_LAST) state_nxt = step_nxt;
         else                 cnt_nxt   = cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a        <= 4'h0;
         r        <= 4'h0;
         s        <= 4'h0;
         result_q <= 4'h0;
         zero_q   <= 1'b0;
      end else begin
         if (cap_a) a <= bus.operand;
         if (wr_r)  r <= p;
         if (wr_s)  s <= p;
         // Result is taken straight from the final product so it is already
         // registered in the done cycle.
         if (wr_res) begin
            result_q <= p;
            zero_q   <= (a == 4'h0);
         end
      end
   end

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_FIN);
   assign bus.result   = result_q;
   assign bus.zero_err = zero_q;

endmodule

// File: tb/tb_gf16_inverse_seq.sv
// Self-checking bench for gf16_inverse_seq against a field-arithmetic model.
module tb_gf16_inverse_seq;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   gf16_inverse_seq_if bus ();

   gf16_inverse_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: full carry-less product, then reduce modulo x^4+x+1 (0x13).
   function automatic int gmul(input int a, input int b);
      int prod = 0;
      for (int i = 0; i < 4; i++) if ((b >> i) & 1) prod ^= (a << i);
      for (int k = 6; k >= 4; k--) if ((prod >> k) & 1) prod ^= (32'h13 << (k - 4));
      return prod;
   endfunction

   // Reference inverse by exhaustive search; 0 maps to 0.
   function automatic int ginv(input int a);
      for (int b = 1; b < 16; b++) if (gmul(a, b) == 1) return b;
      return 0;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation; optionally pulse a second start at cycle glitch_at.
   task automatic run_op(input logic [3:0] op, input int glitch_at, input logic [3:0] glitch_op,
                         input int exp_res, input string tag);
      int n;
      bus.start   = 1'b1;
      bus.operand = op;
      tick();
      bus.start   = 1'b0;
      bus.operand = 4'($urandom);
      chk({tag, " busy_after_start"}, int'(bus.busy), 1);
      n = 1;
      while (!bus.done && n < 40) begin
         bus.start = (n == glitch_at);
         if (n == glitch_at) bus.operand = glitch_op;
         tick();
         n++;
      end
      bus.start = 1'b0;
      chk({tag, " latency"}, n, 26);
      chk({tag, " result"}, int'(bus.result), exp_res);
      chk({tag, " zero_err"}, int'(bus.zero_err), (op == 4'h0) ? 1 : 0);
      tick();
      chk({tag, " done_single"}, int'(bus.done), 0);
      chk({tag, " busy_released"}, int'(bus.busy), 0);
   endtask

   initial begin
      int v, dcnt, d1, d2, r1, r2, low;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.operand = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset result", int'(bus.result), 0);
      chk("reset zero_err", int'(bus.zero_err), 0);
      rst = 1'b0;
      tick();

      run_op(4'h2, -1, 4'h0, 9, "inv2");

      for (int a = 1; a < 16; a++) begin
         run_op(4'(a), -1, 4'h0, ginv(a), "sweep");
         chk("sweep product_is_one", gmul(a, int'(bus.result)), 1);
      end

      run_op(4'h0, -1, 4'h0, 0, "zero");
      run_op(4'h3, -1, 4'h0, 14, "after_zero");

      // Start while busy is ignored; the next start right after done is accepted.
      run_op(4'h4, 5, 4'h5, 13, "busy_ignore");
      run_op(4'h5, -1, 4'h0, 11, "back_to_back");

      // Asynchronous reset mid-operation.
      bus.start = 1'b1;
      bus.operand = 4'h8;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst busy", int'(bus.busy), 0);
      chk("midrst done", int'(bus.done), 0);
      chk("midrst result", int'(bus.result), 0);
      chk("midrst zero_err", int'(bus.zero_err), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      dcnt = 0;
      repeat (40) begin
         tick();
         if (bus.done) dcnt++;
      end
      chk("midrst no_done", dcnt, 0);
      run_op(4'h8, -1, 4'h0, 15, "after_rst");

      for (int i = 0; i < 12; i++) begin
         v = int'($urandom_range(0, 15));
         run_op(4'(v), -1, 4'h0, ginv(v), "rand");
      end

      // Start held high: back-to-back operations every 27 cycles.
      bus.start = 1'b1;
      bus.operand = 4'hA;
      dcnt = 0; d1 = 0; d2 = 0; r1 = -1; r2 = -1; low = 0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (bus.done) begin
            dcnt++;
            if (dcnt == 1) begin d1 = n; r1 = int'(bus.result); end
            if (dcnt == 2) begin d2 = n; r2 = int'(bus.result); end
         end
         if (dcnt == 1 && !bus.busy) low++;
      end
      bus.start = 1'b0;
      chk("held done1_cycle", d1, 26);
      chk("held done2_cycle", d2, 53);
      chk("held done_count", dcnt, 2);
      chk("held result1", r1, 12);
      chk("held result2", r2, 12);
      chk("held busy_gap", low, 1);
      repeat (30) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
